// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset CPU control path:
// opcode/funct constants, FSM state encoding, datapath mux encodings,
// the control bus struct and an instruction classifier.
package mc_cpu_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;

    localparam logic [OP_W-1:0] OpRType = 6'h00;
    localparam logic [OP_W-1:0] OpJ     = 6'h02;
    localparam logic [OP_W-1:0] OpJal   = 6'h03;
    localparam logic [OP_W-1:0] OpBeq   = 6'h04;
    localparam logic [OP_W-1:0] OpBne   = 6'h05;
    localparam logic [OP_W-1:0] OpAddi  = 6'h08;
    localparam logic [OP_W-1:0] OpXori  = 6'h0E;
    localparam logic [OP_W-1:0] OpLw    = 6'h23;
    localparam logic [OP_W-1:0] OpSw    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FnJr  = 6'h08;
    localparam logic [FUNCT_W-1:0] FnAdd = 6'h20;
    localparam logic [FUNCT_W-1:0] FnSub = 6'h22;
    localparam logic [FUNCT_W-1:0] FnSlt = 6'h2A;

    typedef enum logic [2:0] {
        StIf   = 3'd0,
        StId   = 3'd1,
        StEx   = 3'd2,
        StMem  = 3'd3,
        StWb   = 3'd4,
        StHalt = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluXor = 3'd2,
        AluSlt = 3'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        PcAluRes = 2'd0,
        PcAluOut = 2'd1,
        PcJump   = 2'd2,
        PcRegA   = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        DstRd  = 2'd0,
        DstRt  = 2'd1,
        DstR31 = 2'd2
    } reg_dst_e;

    typedef enum logic [1:0] {
        WbAluOut = 2'd0,
        WbMdr    = 2'd1,
        WbPc     = 2'd2
    } reg_src_e;

    typedef enum logic [1:0] {
        SrcBReg   = 2'd0,
        SrcBFour  = 2'd1,
        SrcBImm   = 2'd2,
        SrcBImmSh = 2'd3
    } alu_src_b_e;

    typedef enum logic [3:0] {
        ClsJ, ClsJr, ClsJal, ClsBeq, ClsBne, ClsRAlu, ClsImm, ClsLw, ClsSw, ClsIllegal
    } instr_cls_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_addr_sel;
        logic       mem_we;
        logic       ir_we;
        logic       pc_we;
        logic       a_we;
        logic       b_we;
        logic       reg_we;
        pc_src_e    pc_src;
        reg_dst_e   reg_dst;
        reg_src_e   reg_src;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
    } ctrl_t;

    // Map opcode/funct onto the execution path the FSM follows.
    function automatic instr_cls_e classify(input logic [OP_W-1:0]    op,
                                            input logic [FUNCT_W-1:0] fn);
        instr_cls_e cls;
        cls = ClsIllegal;
        case (op)
            OpRType: begin
                case (fn)
                    FnJr:                 cls = ClsJr;
                    FnAdd, FnSub, FnSlt:  cls = ClsRAlu;
                    default:              cls = ClsIllegal;
                endcase
            end
            OpJ:            cls = ClsJ;
            OpJal:          cls = ClsJal;
            OpBeq:          cls = ClsBeq;
            OpBne:          cls = ClsBne;
            OpAddi, OpXori: cls = ClsImm;
            OpLw:           cls = ClsLw;
            OpSw:           cls = ClsSw;
            default:        cls = ClsIllegal;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the sequencer and the datapath/memory.
// master = sequencer, slave = datapath side.
interface mc_control_fsm_if #(
    parameter int unsigned CNT_W = 32
) ();
    import mc_cpu_pkg::*;

    logic [OP_W-1:0]    opcode;
    logic [FUNCT_W-1:0] funct;
    logic               zero;
    logic               mem_ack;

    logic               mem_req;
    logic               mem_addr_sel;
    logic               mem_we;
    logic               ir_we;
    logic               pc_we;
    logic               a_we;
    logic               b_we;
    logic               reg_we;
    logic [1:0]         pc_src;
    logic [1:0]         reg_dst;
    logic [1:0]         reg_src;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [2:0]         alu_op;
    logic [2:0]         state;
    logic               retire;
    logic [CNT_W-1:0]   retired_cnt;

    modport master (
        input  opcode, funct, zero, mem_ack,
        output mem_req, mem_addr_sel, mem_we, ir_we, pc_we, a_we, b_we, reg_we,
        output pc_src, reg_dst, reg_src, alu_src_a, alu_src_b, alu_op,
        output state, retire, retired_cnt
    );

    modport slave (
        output opcode, funct, zero, mem_ack,
        input  mem_req, mem_addr_sel, mem_we, ir_we, pc_we, a_we, b_we, reg_we,
        input  pc_src, reg_dst, reg_src, alu_src_a, alu_src_b, alu_op,
        input  state, retire, retired_cnt
    );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode: (state, opcode, funct, zero, mem_ack) ->
// control bus, next state and retire strobe.
// MC_CTRL_ILLEGAL_TRAP_EN: unlisted instructions trap to HALT instead of
// retiring as a NOP.
module mc_ctrl_decode
    import mc_cpu_pkg::*;
(
    input  state_e             state_i,
    input  logic [OP_W-1:0]    opcode_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic               zero_i,
    input  logic               mem_ack_i,
    output ctrl_t              ctrl_o,
    output state_e             next_state_o,
    output logic               retire_o
);

    instr_cls_e cls;
    alu_op_e    r_alu_op;

    assign cls      = classify(opcode_i, funct_i);
    assign r_alu_op = (funct_i == FnSub) ? AluSub :
                      (funct_i == FnSlt) ? AluSlt : AluAdd;

    // Per-state control decode and next-state selection.
    always_comb begin
        ctrl_o       = '0;
        next_state_o = state_i;
        retire_o     = 1'b0;

        case (state_i)
            StIf: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.alu_src_b = SrcBFour;
                ctrl_o.alu_op    = AluAdd;
                if (mem_ack_i) begin
                    ctrl_o.ir_we  = 1'b1;
                    ctrl_o.pc_we  = 1'b1;
                    ctrl_o.pc_src = PcAluRes;
                    next_state_o  = StId;
                end
            end

            StId: begin
                if (cls == ClsIllegal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    next_state_o = StHalt;
`else
                    retire_o     = 1'b1;
                    next_state_o = StIf;
`endif
                end else begin
                    // Speculative branch target: ALUOut = PC + (sext(imm) << 2).
                    ctrl_o.a_we      = 1'b1;
                    ctrl_o.b_we      = 1'b1;
                    ctrl_o.alu_src_b = SrcBImmSh;
                    ctrl_o.alu_op    = AluAdd;
                    if (cls == ClsJ) begin
                        ctrl_o.pc_we  = 1'b1;
                        ctrl_o.pc_src = PcJump;
                        retire_o      = 1'b1;
                        next_state_o  = StIf;
                    end else begin
                        next_state_o = StEx;
                    end
                end
            end

            StEx: begin
                case (cls)
                    ClsJr: begin
                        ctrl_o.pc_we  = 1'b1;
                        ctrl_o.pc_src = PcRegA;
                        retire_o      = 1'b1;
                        next_state_o  = StIf;
                    end
                    ClsJal: begin
                        ctrl_o.reg_we  = 1'b1;
                        ctrl_o.reg_dst = DstR31;
                        ctrl_o.reg_src = WbPc;
                        ctrl_o.pc_we   = 1'b1;
                        ctrl_o.pc_src  = PcJump;
                        retire_o       = 1'b1;
                        next_state_o   = StIf;
                    end
                    ClsBeq, ClsBne: begin
                        ctrl_o.alu_src_a = 1'b1;
                        ctrl_o.alu_src_b = SrcBReg;
                        ctrl_o.alu_op    = AluSub;
                        ctrl_o.pc_src    = PcAluOut;
                        ctrl_o.pc_we     = (cls == ClsBeq) ? zero_i : !zero_i;
                        retire_o         = 1'b1;
                        next_state_o     = StIf;
                    end
                    ClsRAlu: begin
                        ctrl_o.alu_src_a = 1'b1;
                        ctrl_o.alu_src_b = SrcBReg;
                        ctrl_o.alu_op    = r_alu_op;
                        next_state_o     = StWb;
                    end
                    ClsImm: begin
                        ctrl_o.alu_src_a = 1'b1;
                        ctrl_o.alu_src_b = SrcBImm;
                        ctrl_o.alu_op    = (opcode_i == OpXori) ? AluXor : AluAdd;
                        next_state_o     = StWb;
                    end
                    ClsLw, ClsSw: begin
                        ctrl_o.alu_src_a = 1'b1;
                        ctrl_o.alu_src_b = SrcBImm;
                        ctrl_o.alu_op    = AluAdd;
                        next_state_o     = StMem;
                    end
                    default: next_state_o = StIf;
                endcase
            end

            StMem: begin
                ctrl_o.mem_req      = 1'b1;
                ctrl_o.mem_addr_sel = 1'b1;
                ctrl_o.mem_we       = (cls == ClsSw);
                if (mem_ack_i) begin
                    if (cls == ClsSw) begin
                        retire_o     = 1'b1;
                        next_state_o = StIf;
                    end else begin
                        next_state_o = StWb;
                    end
                end
            end

            StWb: begin
                ctrl_o.reg_we  = 1'b1;
                ctrl_o.reg_dst = (cls == ClsRAlu) ? DstRd : DstRt;
                ctrl_o.reg_src = (cls == ClsLw) ? WbMdr : WbAluOut;
                retire_o       = 1'b1;
                next_state_o   = StIf;
            end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            // Sticky trap: only reset leaves HALT.
            StHalt: next_state_o = StHalt;
`endif

            default: next_state_o = StIf;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control sequencer: state register, retired-instruction
// counter and the control bus driven from mc_ctrl_decode.
// MC_CTRL_ILLEGAL_TRAP_EN: enables the HALT trap for unlisted instructions.
module mc_control_fsm
    import mc_cpu_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    mc_control_fsm_if.master  ctrl_io
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl;
    logic             retire;

    mc_ctrl_decode u_decode (
        .state_i      (state_q),
        .opcode_i     (ctrl_io.opcode),
        .funct_i      (ctrl_io.funct),
        .zero_i       (ctrl_io.zero),
        .mem_ack_i    (ctrl_io.mem_ack),
        .ctrl_o       (ctrl),
        .next_state_o (state_d),
        .retire_o     (retire)
    );

    // Retire counter wraps naturally at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIf;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ctrl_io.mem_req      = ctrl.mem_req;
    assign ctrl_io.mem_addr_sel = ctrl.mem_addr_sel;
    assign ctrl_io.mem_we       = ctrl.mem_we;
    assign ctrl_io.ir_we        = ctrl.ir_we;
    assign ctrl_io.pc_we        = ctrl.pc_we;
    assign ctrl_io.a_we         = ctrl.a_we;
    assign ctrl_io.b_we         = ctrl.b_we;
    assign ctrl_io.reg_we       = ctrl.reg_we;
    assign ctrl_io.pc_src       = ctrl.pc_src;
    assign ctrl_io.reg_dst      = ctrl.reg_dst;
    assign ctrl_io.reg_src      = ctrl.reg_src;
    assign ctrl_io.alu_src_a    = ctrl.alu_src_a;
    assign ctrl_io.alu_src_b    = ctrl.alu_src_b;
    assign ctrl_io.alu_op       = ctrl.alu_op;
    assign ctrl_io.state        = state_q;
    assign ctrl_io.retire       = retire;
    assign ctrl_io.retired_cnt  = cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed, table-driven bench for mc_control_fsm. A narrow counter is used
// so the wrap boundary is reachable in a short run.
module tb_mc_control_fsm;

    localparam int unsigned CNT_W = 4;

    logic clk;
    logic reset;

    mc_control_fsm_if #(.CNT_W(CNT_W)) bus ();

    mc_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .ctrl_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]       op;
        logic [5:0]       fn;
        logic             zero;
        logic             ack;
        logic [2:0]       st;
        logic [19:0]      ctl;
        logic             ret;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Packed expected control word, field order matches obs_ctl().
    function automatic logic [19:0] ctl(
        input logic mreq, input logic masel, input logic mwe, input logic irwe,
        input logic pcwe, input logic awe, input logic bwe, input logic rwe,
        input logic [1:0] pcs, input logic [1:0] rd, input logic [1:0] rs,
        input logic asa, input logic [1:0] asb, input logic [2:0] aop);
        return {mreq, masel, mwe, irwe, pcwe, awe, bwe, rwe, pcs, rd, rs, asa, asb, aop};
    endfunction

    function automatic logic [19:0] obs_ctl();
        return {bus.mem_req, bus.mem_addr_sel, bus.mem_we, bus.ir_we, bus.pc_we, bus.a_we,
                bus.b_we, bus.reg_we, bus.pc_src, bus.reg_dst, bus.reg_src, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op};
    endfunction

    logic [19:0] c_ifw, c_ifa, c_id, c_jid, c_zero, c_wbr, c_wbi, c_wbl, c_meml, c_mems;
    logic [19:0] c_jal, c_jr, c_beq_t, c_bne_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic a, input logic [2:0] st, input logic [19:0] c,
                       input logic r, input logic [CNT_W-1:0] n);
        vec_t v;
        v.op = op; v.fn = fn; v.zero = z; v.ack = a;
        v.st = st; v.ctl = c; v.ret = r; v.cnt = n;
        vecs.push_back(v);
    endtask

    // Apply inputs at the falling edge, check the decoded outputs 1 ns later.
    task automatic step(input string name, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic a, input logic [2:0] st,
                        input logic [19:0] c, input logic r, input logic [CNT_W-1:0] n);
        @(negedge clk);
        bus.opcode = op; bus.funct = fn; bus.zero = z; bus.mem_ack = a;
        #1;
        check({name, " state"}, 32'(bus.state), 32'(st));
        check({name, " ctl"}, 32'(obs_ctl()), 32'(c));
        check({name, " retire"}, 32'(bus.retire), 32'(r));
        check({name, " cnt"}, 32'(bus.retired_cnt), 32'(n));
    endtask

    logic [CNT_W-1:0] exp_cnt;

    initial begin
        c_ifw   = ctl(1,0,0,0,0,0,0,0, 2'd0,2'd0,2'd0, 0,2'd1,3'd0);
        c_ifa   = ctl(1,0,0,1,1,0,0,0, 2'd0,2'd0,2'd0, 0,2'd1,3'd0);
        c_id    = ctl(0,0,0,0,0,1,1,0, 2'd0,2'd0,2'd0, 0,2'd3,3'd0);
        c_jid   = ctl(0,0,0,0,1,1,1,0, 2'd2,2'd0,2'd0, 0,2'd3,3'd0);
        c_zero  = '0;
        c_wbr   = ctl(0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd0, 0,2'd0,3'd0);
        c_wbi   = ctl(0,0,0,0,0,0,0,1, 2'd0,2'd1,2'd0, 0,2'd0,3'd0);
        c_wbl   = ctl(0,0,0,0,0,0,0,1, 2'd0,2'd1,2'd1, 0,2'd0,3'd0);
        c_meml  = ctl(1,1,0,0,0,0,0,0, 2'd0,2'd0,2'd0, 0,2'd0,3'd0);
        c_mems  = ctl(1,1,1,0,0,0,0,0, 2'd0,2'd0,2'd0, 0,2'd0,3'd0);
        c_jal   = ctl(0,0,0,0,1,0,0,1, 2'd2,2'd2,2'd2, 0,2'd0,3'd0);
        c_jr    = ctl(0,0,0,0,1,0,0,0, 2'd3,2'd0,2'd0, 0,2'd0,3'd0);
        c_beq_t = ctl(0,0,0,0,1,0,0,0, 2'd1,2'd0,2'd0, 1,2'd0,3'd1);
        c_bne_t = ctl(0,0,0,0,0,0,0,0, 2'd1,2'd0,2'd0, 1,2'd0,3'd1);

        // ADD: IF ID EX WB
        add(6'h00,6'h20,0,1, 3'd0,c_ifa,0,0);
        add(6'h00,6'h20,0,0, 3'd1,c_id,0,0);
        add(6'h00,6'h20,0,0, 3'd2,ctl(0,0,0,0,0,0,0,0,0,0,0,1,2'd0,3'd0),0,0);
        add(6'h00,6'h20,0,0, 3'd4,c_wbr,1,0);
        // SUB
        add(6'h00,6'h22,0,1, 3'd0,c_ifa,0,1);
        add(6'h00,6'h22,0,0, 3'd1,c_id,0,1);
        add(6'h00,6'h22,0,0, 3'd2,ctl(0,0,0,0,0,0,0,0,0,0,0,1,2'd0,3'd1),0,1);
        add(6'h00,6'h22,0,0, 3'd4,c_wbr,1,1);
        // LW with two wait cycles in IF and in MEM: 9 cycles
        add(6'h23,6'h00,0,0, 3'd0,c_ifw,0,2);
        add(6'h23,6'h00,0,0, 3'd0,c_ifw,0,2);
        add(6'h23,6'h00,0,1, 3'd0,c_ifa,0,2);
        add(6'h23,6'h00,0,0, 3'd1,c_id,0,2);
        add(6'h23,6'h00,0,0, 3'd2,ctl(0,0,0,0,0,0,0,0,0,0,0,1,2'd2,3'd0),0,2);
        add(6'h23,6'h00,0,0, 3'd3,c_meml,0,2);
        add(6'h23,6'h00,0,0, 3'd3,c_meml,0,2);
        add(6'h23,6'h00,0,1, 3'd3,c_meml,0,2);
        add(6'h23,6'h00,0,0, 3'd4,c_wbl,1,2);
        // BEQ taken
        add(6'h04,6'h00,1,1, 3'd0,c_ifa,0,3);
        add(6'h04,6'h00,1,0, 3'd1,c_id,0,3);
        add(6'h04,6'h00,1,0, 3'd2,c_beq_t,1,3);
        // BNE with zero set: not taken
        add(6'h05,6'h00,1,1, 3'd0,c_ifa,0,4);
        add(6'h05,6'h00,1,0, 3'd1,c_id,0,4);
        add(6'h05,6'h00,1,0, 3'd2,c_bne_t,1,4);
        // JAL
        add(6'h03,6'h00,0,1, 3'd0,c_ifa,0,5);
        add(6'h03,6'h00,0,0, 3'd1,c_id,0,5);
        add(6'h03,6'h00,0,0, 3'd2,c_jal,1,5);
        // J retires in ID
        add(6'h02,6'h00,0,1, 3'd0,c_ifa,0,6);
        add(6'h02,6'h00,0,0, 3'd1,c_jid,1,6);
        // JR
        add(6'h00,6'h08,0,1, 3'd0,c_ifa,0,7);
        add(6'h00,6'h08,0,0, 3'd1,c_id,0,7);
        add(6'h00,6'h08,0,0, 3'd2,c_jr,1,7);
        // SW with one MEM wait
        add(6'h2B,6'h00,0,1, 3'd0,c_ifa,0,8);
        add(6'h2B,6'h00,0,0, 3'd1,c_id,0,8);
        add(6'h2B,6'h00,0,0, 3'd2,ctl(0,0,0,0,0,0,0,0,0,0,0,1,2'd2,3'd0),0,8);
        add(6'h2B,6'h00,0,0, 3'd3,c_mems,0,8);
        add(6'h2B,6'h00,0,1, 3'd3,c_mems,1,8);
        // ADDI with mem_ack held high outside request cycles (must be ignored)
        add(6'h08,6'h00,0,1, 3'd0,c_ifa,0,9);
        add(6'h08,6'h00,0,1, 3'd1,c_id,0,9);
        add(6'h08,6'h00,0,1, 3'd2,ctl(0,0,0,0,0,0,0,0,0,0,0,1,2'd2,3'd0),0,9);
        add(6'h08,6'h00,0,1, 3'd4,c_wbi,1,9);
        // XORI
        add(6'h0E,6'h00,0,1, 3'd0,c_ifa,0,10);
        add(6'h0E,6'h00,0,0, 3'd1,c_id,0,10);
        add(6'h0E,6'h00,0,0, 3'd2,ctl(0,0,0,0,0,0,0,0,0,0,0,1,2'd2,3'd2),0,10);
        add(6'h0E,6'h00,0,0, 3'd4,c_wbi,1,10);
        // SLT
        add(6'h00,6'h2A,0,1, 3'd0,c_ifa,0,11);
        add(6'h00,6'h2A,0,0, 3'd1,c_id,0,11);
        add(6'h00,6'h2A,0,0, 3'd2,ctl(0,0,0,0,0,0,0,0,0,0,0,1,2'd0,3'd3),0,11);
        add(6'h00,6'h2A,0,0, 3'd4,c_wbr,1,11);
        add(6'h00,6'h00,0,0, 3'd0,c_ifw,0,12);

        // Reset state
        reset = 1'b1;
        bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", 32'(bus.state), 32'd0);
        check("reset ctl", 32'(obs_ctl()), 32'(c_ifw));
        check("reset retire", 32'(bus.retire), 32'd0);
        check("reset cnt", 32'(bus.retired_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].zero, vecs[i].ack,
                 vecs[i].st, vecs[i].ctl, vecs[i].ret, vecs[i].cnt);
        end

        // Reset during LW MEM: aborts asynchronously with no write-back
        step("rst_lw if", 6'h23, 6'h00, 0, 1, 3'd0, c_ifa, 0, 12);
        step("rst_lw id", 6'h23, 6'h00, 0, 0, 3'd1, c_id, 0, 12);
        step("rst_lw ex", 6'h23, 6'h00, 0, 0, 3'd2,
             ctl(0,0,0,0,0,0,0,0,0,0,0,1,2'd2,3'd0), 0, 12);
        step("rst_lw mem", 6'h23, 6'h00, 0, 0, 3'd3, c_meml, 0, 12);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_async state", 32'(bus.state), 32'd0);
        check("rst_async cnt", 32'(bus.retired_cnt), 32'd0);
        check("rst_async reg_we", 32'(bus.reg_we), 32'd0);
        check("rst_async retire", 32'(bus.retire), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step("rst_after", 6'h23, 6'h00, 0, 0, 3'd0, c_ifw, 0, 0);

        // Counter wrap: 16 J instructions on a 4-bit counter
        exp_cnt = '0;
        for (int k = 0; k < 16; k++) begin
            step($sformatf("wrap%0d if", k), 6'h02, 6'h00, 0, 1, 3'd0, c_ifa, 0, exp_cnt);
            step($sformatf("wrap%0d id", k), 6'h02, 6'h00, 0, 0, 3'd1, c_jid, 1, exp_cnt);
            exp_cnt = exp_cnt + 1'b1;
        end
        step("wrap end", 6'h00, 6'h00, 0, 0, 3'd0, c_ifw, 0, 0);

        // Unlisted opcode 0x3F
        step("ill if", 6'h3F, 6'h00, 0, 1, 3'd0, c_ifa, 0, 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        step("ill id", 6'h3F, 6'h00, 0, 0, 3'd1, c_zero, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step($sformatf("halt%0d", k), 6'h3F, 6'h00, 0, 1, 3'd5, c_zero, 0, 0);
        end
`else
        step("ill id", 6'h3F, 6'h00, 0, 0, 3'd1, c_zero, 1, 0);
        step("ill next", 6'h3F, 6'h00, 0, 0, 3'd0, c_ifw, 0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
